div_seq: RTL and testbench

//  Multi-cycle sequencer for the EX-stage divide resource (DIV/DIVU). It accepts
//  one divide request from EX and runs a radix-2 restoring shift-subtract loop.
//  It holds the pipeline stall request high until the 2*WIDTH-bit {remainder,

---
 rtl/div_seq.sv | 157 +++++++++++++++
 tb/tb_div_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
//   Multi-cycle sequencer for the EX-stage divider (DIV / DIVU). Runs a radix-2
//   restoring shift-subtract loop, one iteration per clock, and raises the
//   pipeline stall request until the {remainder, quotient} result is ready for
//   the HI/LO write. Only one divide is in flight at a time.
//
//   Handshake: EX raises start_i with the operands and keeps it high. The
//   operands are captured only in IDLE on the accepting edge. ready_o goes high
//   in END with result_o valid and stable. The divider returns to IDLE on the
//   first cycle that start_i is low in END. annul_i cancels a request in IDLE or
//   a divide in ON. annul_i is ignored in DIVZERO and END.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   start_i       divide request, held high until ready_o
//   annul_i       cancel the in-flight divide (branch / flush)
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   result_o      {remainder, quotient}, valid while ready_o is high
//   ready_o       result valid (END state only)
//   stallreq_o    stall request to the pipeline controller
// -----------------------------------------------------------------------------
module div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stallreq_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIVZERO = 2'd1,
      S_ON      = 2'd2,
      S_END     = 2'd3
   } state_e;

   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   // Bits [2W:W+1] hold the partial remainder. Bit W is the next dividend bit.
   // Bits [W-1:0] hold the remaining dividend bits with the quotient shifted in
   // at the bottom.
   logic [2*WIDTH:0]   dividend_q;
   logic [2*WIDTH:0]   dividend_d;
   logic [WIDTH-1:0]   divisor_q;
   logic               sign_q;     // quotient must be negated
   logic               sign_r_q;   // remainder must be negated

   logic [WIDTH:0]     diff_d;
   logic [WIDTH-1:0]   op1_abs_d;
   logic [WIDTH-1:0]   op2_abs_d;
   logic [WIDTH-1:0]   quot_fix_d;
   logic [WIDTH-1:0]   rem_fix_d;

   always_comb begin
      op1_abs_d = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + ONE) : opdata1_i;
      op2_abs_d = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + ONE) : opdata2_i;

      // A borrow out of the trial subtraction (diff_d[WIDTH]) means the divisor
      // did not fit. In that case only shift. Otherwise keep the difference and
      // shift in a 1.
      diff_d = dividend_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};
      if (diff_d[WIDTH]) begin
         dividend_d = {dividend_q[2*WIDTH-1:0], 1'b0};
      end else begin
         dividend_d = {diff_d[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
      end

      // The first iteration compares against an all-zero window and always
      // yields 0. That bit lands in dividend_d[WIDTH] after the last iteration
      // and is not part of the result.
      quot_fix_d = sign_q   ? (~dividend_d[WIDTH-1:0] + ONE)       : dividend_d[WIDTH-1:0];
      rem_fix_d  = sign_r_q ? (~dividend_d[2*WIDTH:WIDTH+1] + ONE) : dividend_d[2*WIDTH:WIDTH+1];

      stallreq_o = ((state_q == S_IDLE) && start_i && !annul_i) ||
                   (state_q == S_ON) || (state_q == S_DIVZERO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         sign_q     <= 1'b0;
         sign_r_q   <= 1'b0;
         result_o   <= '0;
         ready_o    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state_q <= S_DIVZERO;
                  end else begin
                     state_q    <= S_ON;
                     cnt_q      <= '0;
                     divisor_q  <= op2_abs_d;
                     dividend_q <= {{(WIDTH+1){1'b0}}, op1_abs_d};
                     sign_q     <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                     sign_r_q   <= signed_div_i & opdata1_i[WIDTH-1];
                  end
               end
            end
            S_DIVZERO: begin
               dividend_q <= '0;
               result_o   <= '0;
               ready_o    <= 1'b1;
               state_q    <= S_END;
            end
            S_ON: begin
               if (annul_i) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else begin
                  dividend_q <= dividend_d;
                  cnt_q      <= cnt_q + CNT_ONE;
                  // Iterations run for cnt = 0..WIDTH. The last one also
                  // registers the sign-corrected result.
                  if (cnt_q == CNT_LAST) begin
                     state_q  <= S_END;
                     cnt_q    <= '0;
                     result_o <= {rem_fix_d, quot_fix_d};
                     ready_o  <= 1'b1;
                  end
               end
            end
            S_END: begin
               if (!start_i) begin
                  state_q  <= S_IDLE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
//   Self-checking bench for div_seq (WIDTH = 32). The reference model uses
//   64-bit integer division, which truncates toward zero and gives the
//   remainder the dividend's sign. Expected results are queued when a request
//   is issued and popped when ready_o rises.
// -----------------------------------------------------------------------------
module tb_div_seq;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   int          n_checks;
   int          n_errors;
   logic [63:0] exp_q[$];

   div_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stallreq_o   (stallreq_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // ---------------- driver ----------------
   // Issues one divide, checks latency, stall behaviour and result. Holds
   // start_i for hold extra cycles in END, then releases it and checks the
   // return to IDLE.
   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      int          cyc;
      int          exp_lat;
      logic        stall_ok;
      logic        stable_ok;
      logic [63:0] held;
      @(negedge clk);
      start_i      = 1'b1;
      annul_i      = 1'b0;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      exp_q.push_back(ref_div(sgn, a, b));
      exp_lat = (b == 32'd0) ? 2 : 34;
      #1;
      check("stall_accept", 64'(stallreq_o), 64'd1);
      cyc      = 0;
      stall_ok = 1'b1;
      while (!ready_o && cyc < 100) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         // Operands are scrambled after acceptance and must be ignored.
         opdata1_i    = $urandom;
         opdata2_i    = $urandom;
         signed_div_i = 1'($urandom_range(0, 1));
         if (!ready_o && !stallreq_o) stall_ok = 1'b0;
      end
      check("latency", 64'(cyc), 64'(exp_lat));
      check("stall_busy", 64'(stall_ok), 64'd1);
      check("stall_end", 64'(stallreq_o), 64'd0);
      check("result", result_o, exp_q.pop_front());
      if (hold > 0) begin
         held      = result_o;
         stable_ok = 1'b1;
         repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o !== 1'b1 || result_o !== held || stallreq_o !== 1'b0) stable_ok = 1'b0;
         end
         check("end_hold", 64'(stable_ok), 64'd1);
      end
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("idle_ready", 64'(ready_o), 64'd0);
      check("idle_result", result_o, 64'd0);
      check("idle_stall", 64'(stallreq_o), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] corners [6];
   logic        never_ready;
   logic [31:0] ra;
   logic [31:0] rb;

   initial begin
      corners = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000,
                  32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b1;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      repeat (3) @(negedge clk);
      check("rst_result", result_o, 64'd0);
      check("rst_ready", 64'(ready_o), 64'd0);
      check("rst_stall", 64'(stallreq_o), 64'd0);
      rst = 1'b0;

      // Directed cases.
      do_div(1'b0, 32'd100, 32'd7, 0);
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);          // -7 / 2
      do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);          // 7 / -2
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);  // overflow wrap
      do_div(1'b0, 32'd5, 32'd0, 0);                  // divide by zero
      do_div(1'b1, 32'hFFFF_FFFF, 32'd0, 2);          // signed divide by zero, held
      do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
      do_div(1'b0, 32'd3, 32'd10, 0);                 // quotient 0
      do_div(1'b0, 32'd1000, 32'd33, 5);              // hold start_i through END

      // start_i together with annul_i in IDLE: no request taken.
      @(negedge clk);
      start_i   = 1'b1;
      annul_i   = 1'b1;
      opdata1_i = 32'd50;
      opdata2_i = 32'd5;
      #1;
      check("annul_idle_stall", 64'(stallreq_o), 64'd0);
      repeat (3) @(negedge clk);
      check("annul_idle_ready", 64'(ready_o), 64'd0);
      check("annul_idle_stay", 64'(stallreq_o), 64'd0);
      start_i = 1'b0;
      annul_i = 1'b0;

      // Annul in the middle of the loop (iteration 10).
      @(negedge clk);
      start_i      = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = 32'hDEAD_BEEF;
      opdata2_i    = 32'd13;
      repeat (11) @(negedge clk);
      check("annul_on_busy", 64'(stallreq_o), 64'd1);
      start_i = 1'b0;
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      check("annul_on_stall", 64'(stallreq_o), 64'd0);
      check("annul_on_ready", 64'(ready_o), 64'd0);
      never_ready = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (ready_o !== 1'b0 || stallreq_o !== 1'b0) never_ready = 1'b0;
      end
      check("annul_no_result", 64'(never_ready), 64'd1);
      do_div(1'b0, 32'd9, 32'd3, 0);

      // Reset at iteration 20.
      @(negedge clk);
      start_i      = 1'b1;
      signed_div_i = 1'b1;
      opdata1_i    = 32'h8765_4321;
      opdata2_i    = 32'd77;
      repeat (21) @(negedge clk);
      check("rst_mid_busy", 64'(stallreq_o), 64'd1);
      start_i = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      check("rst_mid_stall", 64'(stallreq_o), 64'd0);
      check("rst_mid_ready", 64'(ready_o), 64'd0);
      check("rst_mid_result", result_o, 64'd0);
      rst = 1'b0;
      do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1);          // -100 / 7

      // Randomized divides with corner operands mixed in.
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0:       ra = corners[$urandom_range(0, 5)];
            1:       ra = 32'($urandom_range(0, 255));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0:       rb = corners[$urandom_range(0, 5)];
            1:       rb = 32'($urandom_range(0, 15));
            2:       rb = ~32'($urandom_range(0, 8));
            default: rb = $urandom;
         endcase
         do_div(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
